// File: rtl/point_seq_gen.sv
// Emits P(i) = (i+1)*B for i = 1..count over y^2 = x^3 + 2x + 4 in projective coordinates,
// field GF(2^N-1). Optional macro POINT_SEQ_INF_STOP_EN stops the sequence at the point at infinity.

// Doubling, dbl-1998-cmo-2 formulas; Y==0 or Z==0 yields Z3==0.
module PointDouble #(
    parameter int N = 3,
    parameter int A = 2
) (
    input  logic [N-1:0] i_x,
    input  logic [N-1:0] i_y,
    input  logic [N-1:0] i_z,
    output logic [N-1:0] o_x,
    output logic [N-1:0] o_y,
    output logic [N-1:0] o_z
);
    localparam logic [N-1:0] P    = '1;
    localparam logic [N-1:0] A_FE = N'(A);

    function automatic logic [N-1:0] red(input logic [2*N-1:0] v);
        logic [N:0]   t;
        logic [N-1:0] s;
        t = {1'b0, v[N-1:0]} + {1'b0, v[2*N-1:N]};
        s = t[N-1:0] + {{(N-1){1'b0}}, t[N]};
        return (s == P) ? '0 : s;
    endfunction
    function automatic logic [N-1:0] fmul(input logic [N-1:0] a, input logic [N-1:0] b);
        return red({{N{1'b0}}, a} * {{N{1'b0}}, b});
    endfunction
    function automatic logic [N-1:0] fadd(input logic [N-1:0] a, input logic [N-1:0] b);
        return red({{(N-1){1'b0}}, {1'b0, a} + {1'b0, b}});
    endfunction
    function automatic logic [N-1:0] fsub(input logic [N-1:0] a, input logic [N-1:0] b);
        return fadd(a, ~b);
    endfunction

    logic [N-1:0] w_xx, w_w, w_s, w_r, w_b, w_b2, w_b4, w_b8, w_h, w_rr, w_rr2, w_rr4, w_sss, w_s2, w_s4;

    assign w_xx  = fmul(i_x, i_x);
    assign w_w   = fadd(fmul(A_FE, fmul(i_z, i_z)), fadd(w_xx, fadd(w_xx, w_xx)));
    assign w_s   = fmul(i_y, i_z);
    assign w_r   = fmul(i_y, w_s);
    assign w_b   = fmul(i_x, w_r);
    assign w_b2  = fadd(w_b, w_b);
    assign w_b4  = fadd(w_b2, w_b2);
    assign w_b8  = fadd(w_b4, w_b4);
    assign w_h   = fsub(fmul(w_w, w_w), w_b8);
    assign w_rr  = fmul(w_r, w_r);
    assign w_rr2 = fadd(w_rr, w_rr);
    assign w_rr4 = fadd(w_rr2, w_rr2);
    assign w_sss = fmul(w_s, fmul(w_s, w_s));
    assign w_s2  = fadd(w_sss, w_sss);
    assign w_s4  = fadd(w_s2, w_s2);

    assign o_x = fmul(fadd(w_h, w_h), w_s);
    assign o_y = fsub(fmul(w_w, fsub(w_b4, w_h)), fadd(w_rr4, w_rr4));
    assign o_z = fadd(w_s4, w_s4);
endmodule

// Addition P1 + P2, add-1998-cmo-2 formulas; P1 == -P2 yields Z3 == 0.
module pointAddition #(
    parameter int N = 3
) (
    input  logic [N-1:0] i_x1,
    input  logic [N-1:0] i_y1,
    input  logic [N-1:0] i_z1,
    input  logic [N-1:0] i_x2,
    input  logic [N-1:0] i_y2,
    input  logic [N-1:0] i_z2,
    output logic [N-1:0] o_x,
    output logic [N-1:0] o_y,
    output logic [N-1:0] o_z
);
    localparam logic [N-1:0] P = '1;

    function automatic logic [N-1:0] red(input logic [2*N-1:0] v);
        logic [N:0]   t;
        logic [N-1:0] s;
        t = {1'b0, v[N-1:0]} + {1'b0, v[2*N-1:N]};
        s = t[N-1:0] + {{(N-1){1'b0}}, t[N]};
        return (s == P) ? '0 : s;
    endfunction
    function automatic logic [N-1:0] fmul(input logic [N-1:0] a, input logic [N-1:0] b);
        return red({{N{1'b0}}, a} * {{N{1'b0}}, b});
    endfunction
    function automatic logic [N-1:0] fadd(input logic [N-1:0] a, input logic [N-1:0] b);
        return red({{(N-1){1'b0}}, {1'b0, a} + {1'b0, b}});
    endfunction
    function automatic logic [N-1:0] fsub(input logic [N-1:0] a, input logic [N-1:0] b);
        return fadd(a, ~b);
    endfunction

    logic [N-1:0] w_u, w_v, w_vv, w_vvv, w_z12, w_r, w_a;

    assign w_u   = fsub(fmul(i_y2, i_z1), fmul(i_y1, i_z2));
    assign w_v   = fsub(fmul(i_x2, i_z1), fmul(i_x1, i_z2));
    assign w_vv  = fmul(w_v, w_v);
    assign w_vvv = fmul(w_v, w_vv);
    assign w_z12 = fmul(i_z1, i_z2);
    assign w_r   = fmul(w_vv, fmul(i_x1, i_z2));
    assign w_a   = fsub(fsub(fmul(fmul(w_u, w_u), w_z12), w_vvv), fadd(w_r, w_r));

    assign o_x = fmul(w_v, w_a);
    assign o_y = fsub(fmul(w_u, fsub(w_r, w_a)), fmul(w_vvv, fmul(i_y1, i_z2)));
    assign o_z = fmul(w_vvv, w_z12);
endmodule

module point_seq_gen #(
    parameter int N  = 3,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [N-1:0]  bx,
    input  logic [N-1:0]  by,
    input  logic [N-1:0]  bz,
    input  logic [CW-1:0] count,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_x,
    output logic [N-1:0]  out_y,
    output logic [N-1:0]  out_z,
    output logic [CW-1:0] out_idx,
    output logic          done,
    output logic          inf
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_EMIT, S_FIN} state_t;

    state_t        r_state, w_next;
    logic [N-1:0]  r_bx, r_by, r_bz, r_ax, r_ay, r_az;
    logic [CW-1:0] r_cnt, r_idx;
    logic [N-1:0]  w_dx, w_dy, w_dz, w_sx, w_sy, w_sz;
    logic          w_hs, w_inf, w_last;

    PointDouble #(.N(N)) u_dbl (
        .i_x(r_bx), .i_y(r_by), .i_z(r_bz),
        .o_x(w_dx), .o_y(w_dy), .o_z(w_dz)
    );

    pointAddition #(.N(N)) u_add (
        .i_x1(r_bx), .i_y1(r_by), .i_z1(r_bz),
        .i_x2(r_ax), .i_y2(r_ay), .i_z2(r_az),
        .o_x(w_sx), .o_y(w_sy), .o_z(w_sz)
    );

    assign w_hs = (r_state == S_EMIT) && out_ready;
`ifdef POINT_SEQ_INF_STOP_EN
    assign w_inf = (r_state == S_EMIT) && (r_az == '0);
`else
    assign w_inf = 1'b0;
`endif
    assign w_last = (r_idx == r_cnt) || w_inf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = (count == '0) ? S_FIN : S_CALC;
            S_CALC: w_next = S_EMIT;
            S_EMIT: if (w_hs) w_next = w_last ? S_FIN : S_CALC;
            S_FIN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state == S_CALC) || (r_state == S_EMIT);
        out_valid = (r_state == S_EMIT);
        done      = (r_state == S_FIN);
        inf       = w_inf;
        out_x     = r_ax;
        out_y     = r_ay;
        out_z     = r_az;
        out_idx   = r_idx;
    end

    // Accumulator holds P(idx); the first step doubles B, every later step adds B.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bx  <= '0; r_by <= '0; r_bz <= '0;
            r_ax  <= '0; r_ay <= '0; r_az <= '0;
            r_cnt <= '0; r_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start && count != '0) begin
                    r_bx  <= bx; r_by <= by; r_bz <= bz;
                    r_cnt <= count;
                    r_idx <= CW'(1);
                end
                S_CALC: if (r_idx == CW'(1)) begin
                    r_ax <= w_dx; r_ay <= w_dy; r_az <= w_dz;
                end else begin
                    r_ax <= w_sx; r_ay <= w_sy; r_az <= w_sz;
                end
                S_EMIT: if (w_hs && !w_last) r_idx <= r_idx + CW'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: doc/point_seq_gen.md
POINT_SEQ_GEN -- requirements
Module: point_seq_gen

Interface
REQ-001 SHALL have parameter N, default 3: field-element width of each projective coordinate.
REQ-002 SHALL have parameter CW, default 4: width of the count and index fields.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request to generate a new point sequence.
REQ-006 SHALL have ports bx, by, bz, inputs, N bits each: base point B in projective coordinates, sampled with start.
REQ-007 SHALL have port count, input, CW bits: number of points to emit, sampled with start.
REQ-008 SHALL have port busy, output, 1 bit: high while a sequence is in progress.
REQ-009 SHALL have port out_valid, output, 1 bit: an emitted point is present on the output ports.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the emitted point.
REQ-011 SHALL have ports out_x, out_y, out_z, outputs, N bits each: the emitted projective point.
REQ-012 SHALL have port out_idx, output, CW bits: sequence index i of the emitted point.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse marking the end of a sequence.
REQ-014 SHALL have port inf, output, 1 bit: the emitted point is the point at infinity (out_z==0).

Function
REQ-015 SHALL instantiate exactly one pointAddition and one PointDouble (both N-bit, combinational) and use no other curve arithmetic.
REQ-016 SHALL generate P(1)=PointDouble(B) and P(i)=pointAddition(B, P(i-1)) for i>=2, i.e. P(i)=(i+1)·B.
REQ-017 SHALL implement FSM states IDLE, CALC, EMIT, FIN.
REQ-018 IDLE: busy=0; on start with count!=0, SHALL latch B and count, set idx=1 and go to CALC.
REQ-019 IDLE: on start with count==0, SHALL go to FIN without emitting any point.
REQ-020 CALC: SHALL register the output of the double unit (idx==1) or the add unit (idx>1) into the accumulator, then go to EMIT; this takes 1 cycle.
REQ-021 EMIT: SHALL assert out_valid and drive accumulator/idx onto out_*; outputs SHALL remain stable until out_valid && out_ready.
REQ-022 EMIT handshake with idx==count: SHALL go to FIN; otherwise SHALL increment idx and go to CALC.
REQ-023 FIN: SHALL assert done=1 and busy=0 for exactly one cycle, then go to IDLE.
REQ-024 busy SHALL be 1 in CALC and EMIT, and 0 in IDLE and FIN.
REQ-025 start SHALL be ignored outside IDLE; bx/by/bz/count changes after latching SHALL have no effect.
REQ-026 Latency: start accepted at edge t SHALL give out_valid high from edge t+2; after each accepted handshake, the next out_valid SHALL rise 2 edges later (1 idle cycle).
REQ-027 count=2^CW-1 SHALL emit all indices 1..2^CW-1 with no idx wrap.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, busy=0, out_valid=0, done=0, inf=0, out_x/out_y/out_z=0, out_idx=0 and idx=0, and clear the accumulator, regardless of state.
REQ-029 Reset mid-sequence SHALL abandon the sequence with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Configuration
REQ-030 Macro POINT_SEQ_INF_STOP_EN defined: an EMIT with accumulator Z==0 SHALL assert inf=1; its handshake SHALL go to FIN even if idx<count.
REQ-031 Macro POINT_SEQ_INF_STOP_EN undefined: inf SHALL be tied to 0, and the sequence SHALL always run to idx==count.

Verification
REQ-032 Reset, then start with B=(110,001,001) and count=3, out_ready=1 -> out_idx 1,2,3, each point equal to the reference-model result for that index, out_valid at t+2, t+4, t+6, done at t+7.
REQ-033 Same as REQ-032 with out_ready low for 5 cycles during idx=2 -> out_* stable throughout, no extra or missing points.
REQ-034 start with count=0 -> no out_valid, done=1 at t+1, busy never high.
REQ-035 Assert rst_n low during EMIT of idx=2 -> all outputs 0 immediately, no done pulse; a new start then runs cleanly from idx=1.
REQ-036 Pulse start while busy with a different B -> ignored; the sequence continues with the original B.
REQ-037 With POINT_SEQ_INF_STOP_EN defined, B chosen so that P(k) has Z=0 and count=14 -> inf=1 at idx=k, done follows and no idx>k is emitted; with the macro undefined -> all 14 points emitted and inf=0.
